// File: rtl/mw_skid_stage.sv
// Elastic MEM/WB pipeline stage: a main entry feeding writeback plus a skid entry that
// absorbs one extra payload under back-pressure, with flush, x0 suppression and stall count.
module mw_skid_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int RS_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWriteM,
  input  logic [RS_W-1:0]   ResultSrcM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [RD_W-1:0]   RdM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWriteW,
  output logic [RS_W-1:0]   ResultSrcW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [RD_W-1:0]   RdW,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Skid payload carries RegWrite in its MSB; the main entry keeps it gated in reg_write_w_q.
  localparam int PAY_W  = 1 + RS_W + 3 * DATA_W + RD_W;
  localparam int MAIN_W = PAY_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [MAIN_W-1:0] main_q, main_d;
  logic [PAY_W-1:0]  skid_q, skid_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              cap_rw_s;
  logic [PAY_W-1:0]  in_pay_s;
  logic              accept_s;
  logic              consume_s;
  logic              main_free_s;

  // Capture formatting, handshake decode and next-state selection for both entries.
  always_comb begin
    main_valid_d  = main_valid_q;
    skid_valid_d  = skid_valid_q;
    main_d        = main_q;
    skid_d        = skid_q;
    reg_write_w_d = reg_write_w_q;
    stall_d       = stall_q;

    if (RdM == {RD_W{1'b0}}) begin
      cap_rw_s = 1'b0;
    end else begin
      cap_rw_s = RegWriteM;
    end
    in_pay_s    = {cap_rw_s, ResultSrcM, ALUResultM, ReadDataM, RdM, PCPlus4M};
    accept_s    = in_valid & ~skid_valid_q;
    consume_s   = main_valid_q & out_ready;
    main_free_s = ~main_valid_q | consume_s;

    if (flush) begin
      main_valid_d  = 1'b0;
      skid_valid_d  = 1'b0;
      main_d        = {MAIN_W{1'b0}};
      skid_d        = {PAY_W{1'b0}};
      reg_write_w_d = 1'b0;
    end else begin
      if (main_free_s) begin
        if (skid_valid_q) begin
          main_d        = skid_q[MAIN_W-1:0];
          reg_write_w_d = skid_q[PAY_W-1];
          main_valid_d  = 1'b1;
          skid_valid_d  = 1'b0;
        end else if (accept_s) begin
          main_d        = in_pay_s[MAIN_W-1:0];
          reg_write_w_d = cap_rw_s;
          main_valid_d  = 1'b1;
        end else begin
          main_valid_d  = 1'b0;
          reg_write_w_d = 1'b0;
        end
      end else begin
        if (accept_s) begin
          skid_d       = in_pay_s;
          skid_valid_d = 1'b1;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end

      if (main_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_ONE;
      end else begin
        stall_d = stall_q;
      end
    end
  end

  // State registers; reset clears everything including the stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      main_q        <= {MAIN_W{1'b0}};
      skid_q        <= {PAY_W{1'b0}};
      reg_write_w_q <= 1'b0;
      stall_q       <= {CNT_W{1'b0}};
    end else begin
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      reg_write_w_q <= reg_write_w_d;
      stall_q       <= stall_d;
    end
  end

  assign in_ready     = ~skid_valid_q;
  assign out_valid    = main_valid_q;
  assign RegWriteW    = reg_write_w_q;
  assign {ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W} = main_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mw_skid_stage.sv
// Randomised scoreboard bench for mw_skid_stage: a depth-2 FIFO reference model, plus a
// narrow-counter instance driven in parallel to exercise stall counter saturation.
module tb_mw_skid_stage;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [4:0]  rd;
    logic [31:0] pc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'd0;
  logic [31:0] ALUResultM = 32'd0, ReadDataM = 32'd0, PCPlus4M = 32'd0;
  logic [4:0]  RdM = 5'd0;

  logic        in_ready, out_valid, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic [15:0] stall_cycles;

  logic        s_in_ready, s_out_valid, s_RegWriteW;
  logic [1:0]  s_ResultSrcW;
  logic [31:0] s_ALUResultW, s_ReadDataW, s_PCPlus4W;
  logic [4:0]  s_RdW;
  logic [2:0]  s_stall;

  mw_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .out_valid(out_valid), .out_ready(out_ready), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .RdW(RdW), .PCPlus4W(PCPlus4W), .stall_cycles(stall_cycles)
  );

  mw_skid_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .out_valid(s_out_valid), .out_ready(out_ready), .RegWriteW(s_RegWriteW),
    .ResultSrcW(s_ResultSrcW), .ALUResultW(s_ALUResultW), .ReadDataW(s_ReadDataW),
    .RdW(s_RdW), .PCPlus4W(s_PCPlus4W), .stall_cycles(s_stall)
  );

  int     total = 0;
  int     bad = 0;
  int     occ = 0;
  longint stall_m = 0;
  bit     armed = 1'b0;
  item_t  exp_q[$];

  function automatic longint sat(longint v, longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: applies one cycle of inputs, records an expected
  // item if the model says it will be accepted, and returns just after the next edge.
  task automatic drive(input bit iv, input bit ordy, input logic [31:0] alu,
                       input logic [4:0] rd, input bit rwm, input bit fl, input bit r);
    item_t it;
    in_valid   = iv;
    out_ready  = ordy;
    ALUResultM = alu;
    RdM        = rd;
    RegWriteM  = rwm;
    flush      = fl;
    rst        = r;
    ResultSrcM = 2'($urandom);
    ReadDataM  = $urandom;
    PCPlus4M   = $urandom;
    if (iv && !fl && !r && occ < 2) begin
      it.rw   = rwm && (rd != 5'd0);
      it.rs   = ResultSrcM;
      it.alu  = alu;
      it.rdat = ReadDataM;
      it.rd   = rd;
      it.pc   = PCPlus4M;
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, ordy, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input bit ordy, input logic [31:0] alu);
    drive(1'b1, ordy, alu, 5'd1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic item_t pack_main();
    return {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W};
  endfunction

  function automatic item_t pack_sat();
    return {s_RegWriteW, s_ResultSrcW, s_ALUResultW, s_ReadDataW, s_RdW, s_PCPlus4W};
  endfunction

  // Reference model occupancy: the stage behaves as a two-deep FIFO with registered ready.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      occ = 0; stall_m = 0; exp_q.delete(); armed = 1'b1;
    end else if (flush) begin
      occ = 0; exp_q.delete();
    end else begin
      if (occ > 0 && !out_ready) stall_m++;
      occ = occ - ((occ > 0 && out_ready) ? 1 : 0) + ((in_valid && occ < 2) ? 1 : 0);
    end
  end

  // Monitor: compares presented outputs against the scoreboard head and pops on consume.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("out_valid", out_valid, occ > 0);
      chk("in_ready", in_ready, occ < 2);
      chk("sat_out_valid", s_out_valid, occ > 0);
      chk("sat_in_ready", s_in_ready, occ < 2);
      chk("stall16", stall_cycles, sat(stall_m, 65535));
      chk("stall3", s_stall, sat(stall_m, 7));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          chk("payload", pack_main(), exp_q[0]);
          chk("sat_payload", pack_sat(), exp_q[0]);
          if (out_ready && !rst && !flush) void'(exp_q.pop_front());
        end
      end else begin
        chk("rw_gated", RegWriteW, 1'b0);
        chk("sat_rw_gated", s_RegWriteW, 1'b0);
      end
    end
  end

  initial begin
    longint stall_before;
    #1;
    do_reset();
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_payload", pack_main(), 104'd0);
    chk("rst_stall", stall_cycles, 16'd0);

    send(1'b1, 32'h10);
    chk("stream_0x10", ALUResultW, 32'h10);
    send(1'b1, 32'h20);
    chk("stream_0x20", ALUResultW, 32'h20);
    chk("stream_valid", out_valid, 1'b1);
    send(1'b1, 32'h30);
    chk("stream_0x30", ALUResultW, 32'h30);
    chk("stream_ready", in_ready, 1'b1);
    repeat (3) idle(1'b1);

    do_reset();
    send(1'b0, 32'hA);
    send(1'b0, 32'hB);
    chk("bp_main_a", ALUResultW, 32'hA);
    chk("bp_ready_low", in_ready, 1'b0);
    idle(1'b0);
    chk("bp_stall2", stall_cycles, 16'd2);
    idle(1'b1);
    chk("bp_main_b", ALUResultW, 32'hB);
    chk("bp_ready_high", in_ready, 1'b1);
    idle(1'b1);

    drive(1'b1, 1'b1, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("x0_rd", RdW, 5'd0);
    chk("x0_rw", RegWriteW, 1'b0);
    drive(1'b1, 1'b1, 32'h66, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("x5_rw", RegWriteW, 1'b1);
    repeat (2) idle(1'b1);

    send(1'b0, 32'hC1);
    send(1'b0, 32'hC2);
    stall_before = stall_m;
    drive(1'b1, 1'b0, 32'hC3, 5'd3, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_payload", pack_main(), 104'd0);
    chk("flush_stall", stall_cycles, 16'(stall_before));

    do_reset();
    send(1'b1, 32'h77);
    repeat (10) idle(1'b0);
    chk("sat_stall3", s_stall, 3'd7);
    chk("sat_stall16", stall_cycles, 16'd10);
    repeat (2) idle(1'b1);

    send(1'b0, 32'hD1);
    send(1'b0, 32'hD2);
    drive(1'b1, 1'b0, 32'hD3, 5'd4, 1'b1, 1'b1, 1'b1);
    chk("midrst_payload", pack_main(), 104'd0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_stall", stall_cycles, 16'd0);
    chk("midrst_stall3", s_stall, 3'd0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, ((i / 64) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0),
            $urandom, 5'($urandom % 8), 1'($urandom), ($urandom % 64) == 0, ($urandom % 500) == 0);
    end
    repeat (4) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
